// File: rtl/nn_params_pkg.sv
// Shared constants and loader state encoding for the digit-recognition network front end.
package nn_params_pkg;

    localparam int unsigned N_INPUTS = 62;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned RESULT_W = 4;
    localparam int unsigned LAYER_W  = DATA_W * N_INPUTS;
    localparam int unsigned CNT_W    = $clog2(N_INPUTS);

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/nn_frame_loader_if.sv
// Host byte stream, network start/result and digit return signals of the frame loader.
interface nn_frame_loader_if;
    import nn_params_pkg::*;

    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                in_ready;
    logic                clear;
    logic                nn_start;
    logic [LAYER_W-1:0]  nn_input_layer;
    logic                nn_ready;
    logic [RESULT_W-1:0] nn_result;
    logic                out_valid;
    logic [RESULT_W-1:0] out_digit;
    logic                out_ready;
    logic                busy;

    // Host and network side.
    modport master (
        output in_valid, in_data, clear, nn_ready, nn_result, out_ready,
        input  in_ready, nn_start, nn_input_layer, out_valid, out_digit, busy
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data, clear, nn_ready, nn_result, out_ready,
        output in_ready, nn_start, nn_input_layer, out_valid, out_digit, busy
    );

endinterface

// File: rtl/nn_byte_counter.sv
// Mod-Modulus up-counter with enable, synchronous clear and terminal-count flag.
module nn_byte_counter
    import nn_params_pkg::*;
#(
    parameter int unsigned Modulus = N_INPUTS,
    parameter int unsigned Width   = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [Width-1:0] count,
    output logic             co
);

    logic [Width-1:0] count_q, count_d;

    assign co    = (count_q == Width'(Modulus - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = co ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nn_frame_loader.sv
// Assembles a serial pixel stream into the network input vector, starts the network and
// returns its digit over a valid/ready handshake.
module nn_frame_loader
    import nn_params_pkg::*;
(
    input logic              clk,
    input logic              rst,
    nn_frame_loader_if.slave bus
);

    loader_state_e       state_q, state_d;
    logic [CNT_W-1:0]    byte_cnt;
    logic                last_byte;
    logic                load_clr;
    logic                accept;
    logic                nn_ready_q;
    logic                done_edge;
    logic [LAYER_W-1:0]  layer_q, layer_d;
    logic [RESULT_W-1:0] digit_q;

    // Clear only acts in LOAD and beats a coincident byte.
    assign load_clr  = (state_q == StLoad) & bus.clear;
    assign accept    = (state_q == StLoad) & bus.in_valid & ~bus.clear;
    assign done_edge = bus.nn_ready & ~nn_ready_q;

    nn_byte_counter #(
        .Modulus (N_INPUTS),
        .Width   (CNT_W)
    ) u_byte_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .clr   (load_clr),
        .count (byte_cnt),
        .co    (last_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StLoad:  if (accept && last_byte) state_d = StStart;
            StStart: state_d = StRun;
            StRun:   if (done_edge) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.nn_start  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state_q)
            StLoad: begin
                bus.in_ready = ~rst;
                bus.busy     = 1'b0;
            end
            StStart: bus.nn_start  = 1'b1;
            StDone:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        layer_d = layer_q;
        for (int unsigned k = 0; k < N_INPUTS; k++) begin
            if (accept && byte_cnt == CNT_W'(k)) begin
                layer_d[k*DATA_W +: DATA_W] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_q    <= '0;
            digit_q    <= '0;
            nn_ready_q <= 1'b0;
        end else begin
            layer_q    <= layer_d;
            nn_ready_q <= bus.nn_ready;
            if (state_q == StRun && done_edge) begin
                digit_q <= bus.nn_result;
            end
        end
    end

    assign bus.nn_input_layer = layer_q;
    assign bus.out_digit      = digit_q;

endmodule

// File: tb/tb_nn_frame_loader.sv
// Self-checking bench for nn_frame_loader: table of frame scenarios with random pixel streams,
// a behavioural network model and a hand-written reset-during-compute sequence.
module tb_nn_frame_loader;
    import nn_params_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nn_frame_loader_if bus ();

    nn_frame_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int unsigned lat;       // cycles from the network seeing nn_start to raising nn_ready
        logic [3:0]  res;
        bit          level;     // ready held high while idle, else a one-cycle done pulse
        int unsigned hold;      // cycles out_ready stays low in DONE
        bit          gappy;
        int          clear_after;
        bit          seq;       // bytes 0x00..0x3D instead of random
        bit          tie;       // out_ready tied high
        int unsigned exp_lat;   // nn_start cycle to first out_valid cycle
        logic [3:0]  exp_digit;
    } vec_t;

    vec_t vecs[6];
    vec_t vreset;
    vec_t vfinal;

    // Network model: reset by the same rst as the loader.
    int unsigned net_lat   = 1;
    logic [3:0]  net_res   = 4'd0;
    bit          net_level = 1'b0;
    int unsigned net_cnt;
    bit          net_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            net_busy      <= 1'b0;
            net_cnt       <= 0;
            bus.nn_ready  <= net_level;
            bus.nn_result <= 4'd0;
        end else if (net_busy) begin
            if (net_cnt == net_lat) begin
                bus.nn_ready  <= 1'b1;
                bus.nn_result <= net_res;
                net_busy      <= 1'b0;
            end else begin
                net_cnt <= net_cnt + 1;
            end
        end else if (bus.nn_start) begin
            net_busy      <= 1'b1;
            net_cnt       <= 1;
            bus.nn_ready  <= 1'b0;
            bus.nn_result <= ~net_res;
        end else begin
            bus.nn_ready <= net_level;
        end
    end

    logic [7:0] frame_q[$];

    function automatic logic [LAYER_W-1:0] pack_frame();
        logic [LAYER_W-1:0] r = '0;
        foreach (frame_q[k]) r[k*8 +: 8] = frame_q[k];
        return r;
    endfunction

    task automatic check(input string name, input logic [LAYER_W-1:0] act,
                         input logic [LAYER_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input vec_t v);
        int         accepts = 0;
        bit         cleared = 1'b0;
        int         guard   = 0;
        logic [7:0] d;
        net_lat       = v.lat;
        net_res       = v.res;
        net_level     = v.level;
        bus.out_ready = v.tie;
        frame_q.delete();
        while (frame_q.size() < N_INPUTS && guard < 4000) begin
            check("load_in_ready", bus.in_ready, 1);
            check("load_busy", bus.busy, 0);
            check("load_no_start", bus.nn_start, 0);
            check("load_out_valid", bus.out_valid, 0);
            bus.in_valid = v.gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            d            = v.seq ? 8'(frame_q.size()) : 8'($urandom);
            bus.in_data  = d;
            bus.clear    = 1'b0;
            if (bus.in_valid && !cleared && v.clear_after >= 0 && accepts == v.clear_after) begin
                bus.clear = 1'b1;
                cleared   = 1'b1;
            end
            if (bus.clear) begin
                frame_q.delete();
            end else if (bus.in_valid) begin
                frame_q.push_back(d);
                accepts++;
            end
            step();
            guard++;
        end
        check("load_bound", frame_q.size(), N_INPUTS);
        bus.in_valid = 1'b1;
        bus.clear    = 1'b0;
        check("start_pulse", bus.nn_start, 1);
        check("start_in_ready", bus.in_ready, 0);
        check("start_busy", bus.busy, 1);
        check("start_layer", bus.nn_input_layer, pack_frame());
        if (v.seq) begin
            check("layer_first_byte", bus.nn_input_layer[7:0], 8'h00);
            check("layer_last_byte", bus.nn_input_layer[495:488], 8'h3d);
        end
    endtask

    task automatic finish_frame(input vec_t v);
        logic [LAYER_W-1:0] exp_layer = pack_frame();
        int unsigned        cyc;
        step();
        cyc = 1;
        while (!bus.out_valid && cyc < v.exp_lat + 20) begin
            check("run_in_ready", bus.in_ready, 0);
            check("run_busy", bus.busy, 1);
            check("run_no_start", bus.nn_start, 0);
            check("run_layer_stable", bus.nn_input_layer, exp_layer);
            bus.in_data = 8'($urandom);
            bus.clear   = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        check("result_latency", cyc, v.exp_lat);
        check("done_digit", bus.out_digit, v.exp_digit);
        check("done_in_ready", bus.in_ready, 0);
        check("done_busy", bus.busy, 1);
        check("done_no_start", bus.nn_start, 0);
        if (!v.tie) begin
            for (int i = 0; i < int'(v.hold); i++) begin
                bus.out_ready = 1'b0;
                step();
                check("hold_valid", bus.out_valid, 1);
                check("hold_digit", bus.out_digit, v.exp_digit);
            end
        end
        bus.out_ready = 1'b1;
        step();
        check("release_valid", bus.out_valid, 0);
        check("release_in_ready", bus.in_ready, 1);
        check("release_busy", bus.busy, 0);
        bus.in_valid  = 1'b0;
        bus.clear     = 1'b0;
        bus.out_ready = v.tie;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.clear     = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{32'd200, 4'd7,  1'b0, 32'd3, 1'b0, -1, 1'b1, 1'b0, 32'd202, 4'd7};
        vecs[1] = '{32'd20,  4'd3,  1'b0, 32'd1, 1'b1, 30, 1'b0, 1'b0, 32'd22,  4'd3};
        vecs[2] = '{32'd15,  4'd9,  1'b1, 32'd2, 1'b1, -1, 1'b0, 1'b0, 32'd17,  4'd9};
        vecs[3] = '{32'd5,   4'd12, 1'b0, 32'd0, 1'b0, -1, 1'b0, 1'b0, 32'd7,   4'd12};
        vecs[4] = '{32'd8,   4'd4,  1'b1, 32'd0, 1'b0, -1, 1'b0, 1'b1, 32'd10,  4'd4};
        vecs[5] = '{32'd3,   4'd15, 1'b0, 32'd0, 1'b1, -1, 1'b0, 1'b1, 32'd5,   4'd15};
        vreset  = '{32'd200, 4'd6,  1'b1, 32'd0, 1'b0, -1, 1'b0, 1'b0, 32'd202, 4'd6};
        vfinal  = '{32'd11,  4'd10, 1'b1, 32'd1, 1'b1, -1, 1'b0, 1'b0, 32'd13,  4'd10};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_start", bus.nn_start, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_layer", bus.nn_input_layer, 0);
        check("rst_digit", bus.out_digit, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        step();

        foreach (vecs[r]) begin
            load_frame(vecs[r]);
            finish_frame(vecs[r]);
        end

        // Abort 50 cycles into compute, then a normal frame.
        load_frame(vreset);
        bus.in_valid = 1'b0;
        repeat (50) step();
        check("midrun_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_start", bus.nn_start, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_layer", bus.nn_input_layer, 0);
        check("abort_digit", bus.out_digit, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("abort_release_in_ready", bus.in_ready, 1);
        step();
        load_frame(vfinal);
        finish_frame(vfinal);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
